// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one full-subtractor cell per clock.
// A start/busy/done handshake issues operations; results hold until the next done or reset.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x, y, d_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  assign x         = a_q[0];
  assign y         = b_q[0];
  assign d_bit     = x ^ y ^ br_q;
  assign br_next   = (~x & y) | (~(x ^ y) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // Publish on the edge entering DONE so partial results are never visible.
        if (cnt_q == LastCnt) begin
          diff_d  = res_shift;
          bout_d  = br_next;
          zero_d  = (res_shift == '0);
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, ignored starts, mid-op reset and a
// randomized sweep against an integer-arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start, bin;
  logic [7:0] a, b;
  logic       busy, done, bout, zero;
  logic [7:0] diff;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; borrow iff the true result is negative.
  function automatic logic [8:0] ref_sub(input int ra, input int rb, input int rbin);
    int r;
    r = ra - rb - rbin;
    return {r < 0 ? 1'b1 : 1'b0, 8'((r + 512) % 256)};
  endfunction

  // Launches one operation from an IDLE cycle and observes it; spurious starts are pulsed in
  // cycles s1/s2 (cycle k is sampled at edge k). Returns in the IDLE cycle after done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input int s1, input int s2,
                       output logic [7:0] od, output logic obo, output logic oz,
                       output int done_at, output int busy_cycles, output bit hold_ok,
                       output logic done_after, output logic busy_after);
    logic [9:0] prev;
    prev = {diff, bout, zero};
    od = 'x; obo = 1'bx; oz = 1'bx;
    done_at = -1; busy_cycles = 0; hold_ok = 1'b1; done_after = 1'b0; busy_after = 1'b0;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cycles++;
      start = (k == s1 || k == s2);
      if (start) begin a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); end
      if (done) begin
        done_at = k; od = diff; obo = bout; oz = zero;
        @(posedge clk); #1;
        start = 1'b0;
        done_after = done; busy_after = busy;
        break;
      end
      if ({diff, bout, zero} !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, diff, bout, zero} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%0d bout=%b zero=%b, want all 0",
               busy, done, diff, bout, zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                               input logic [7:0] ed, input logic eb, input logic ez);
    logic [7:0] d; logic bo, z, da, ba; int dat, bc; bit hk;
    do_op(ia, ib, ibin, 0, 0, d, bo, z, dat, bc, hk, da, ba);
    vectors++;
    if ({d, bo, z} !== {ed, eb, ez}) begin
      miscompares++;
      $display("FAIL directed_result %0d-%0d-%0d: got diff=%0d bout=%b zero=%b, want %0d %b %b",
               ia, ib, ibin, d, bo, z, ed, eb, ez);
    end
    vectors++;
    if (dat !== 9 || bc !== 8) begin
      miscompares++;
      $display("FAIL directed_timing: got done cycle %0d busy cycles %0d, want 9 and 8", dat, bc);
    end
    vectors++;
    if (!hk || da !== 1'b0) begin
      miscompares++;
      $display("FAIL directed_hold_pulse: got hold_ok=%b done_after=%b, want 1 and 0", hk, da);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] d; logic bo, z, da, ba; int dat, bc; bit hk;
    do_op(8'd200, 8'd1, 1'b0, 3, 9, d, bo, z, dat, bc, hk, da, ba);
    vectors++;
    if (d !== 8'd199 || bo !== 1'b0 || dat !== 9) begin
      miscompares++;
      $display("FAIL start_ignored: got diff=%0d bout=%b done cycle %0d, want 199 0 9",
               d, bo, dat);
    end
    vectors++;
    if (da !== 1'b0 || ba !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored_after: got done=%b busy=%b, want 0 0", da, ba);
    end
    do_op(8'd20, 8'd7, 1'b0, 0, 0, d, bo, z, dat, bc, hk, da, ba);
    vectors++;
    if (d !== 8'd13 || dat !== 9) begin
      miscompares++;
      $display("FAIL start_next_idle: got diff=%0d done cycle %0d, want 13 9", d, dat);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] d; logic bo, z, da, ba; int dat, bc, dones;
    bit hk;
    // Leave a nonzero result behind so the clear is observable.
    do_op(8'd200, 8'd1, 1'b0, 0, 0, d, bo, z, dat, bc, hk, da, ba);
    a = 8'd77; b = 8'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midop_busy: got busy=%b in cycle 4, want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({busy, done, diff, bout, zero} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_midop_clear: got busy=%b done=%b diff=%0d bout=%b zero=%b, want 0",
               busy, done, diff, bout, zero);
    end
    dones = 0;
    repeat (12) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_midop_nodone: got %0d done pulses, want 0", dones);
    end
    do_op(8'd10, 8'd4, 1'b0, 0, 0, d, bo, z, dat, bc, hk, da, ba);
    vectors++;
    if (d !== 8'd6 || bo !== 1'b0 || dat !== 9) begin
      miscompares++;
      $display("FAIL reset_then_op: got diff=%0d bout=%b done cycle %0d, want 6 0 9", d, bo, dat);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, ra, rb; logic bo, z, da, ba, rbin; int dat, bc; bit hk;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      exp = ref_sub(int'(ra), int'(rb), int'(rbin));
      do_op(ra, rb, rbin, 0, 0, d, bo, z, dat, bc, hk, da, ba);
      vectors++;
      if ({bo, d} !== exp || z !== (exp[7:0] == 8'd0)) begin
        miscompares++;
        $display("FAIL random %0d-%0d-%0d: got diff=%0d bout=%b zero=%b, want %0d %b %b",
                 ra, rb, rbin, d, bo, z, exp[7:0], exp[8], exp[7:0] == 8'd0);
      end
      vectors++;
      if (dat !== 9 || bc !== 8 || !hk || da !== 1'b0) begin
        miscompares++;
        $display("FAIL random_timing: got done cycle %0d busy %0d hold %b done_after %b",
                 dat, bc, hk, da);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
    test_directed(8'd5, 8'd9, 1'b0, 8'd252, 1'b1, 1'b0);
    test_directed(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0);
    test_directed(8'd42, 8'd42, 1'b0, 8'd0, 1'b0, 1'b1);
    test_start_ignored();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor: computes a - b - bin over WIDTH-bit operands, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow. It is the subtract counterpart to our combinational full-adder cell, for arithmetic paths where area matters more than latency. A start/busy/done handshake lets a controller FSM issue operations and collect results.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk    input   1      system clock, rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
bin    input   1      borrow-in; captured on accepted start
busy   output  1      high while an operation is in progress (SHIFT state)
done   output  1      one-cycle pulse; diff/bout/zero valid from this cycle
diff   output  WIDTH  result a - b - bin mod 2^WIDTH
bout   output  1      final borrow-out; 1 iff a < b + bin (unsigned)
zero   output  1      1 iff diff == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE. busy, done, diff, bout and zero all 0. Internal operand shift registers, borrow register and bit counter all 0. rst has priority over every other input.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: latch a and b into shift registers, load the borrow register with bin, clear the counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy=1):
  - Each cycle processes the current LSBs x and y with the registered borrow br.
  - Difference bit d = x ^ y ^ br.
  - Next borrow = (~x & y) | (~(x ^ y) & br).
  - d shifts into the MSB of an internal result register, which shifts right. Operand registers shift right. Counter increments.
  - After exactly WIDTH SHIFT cycles, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - diff is loaded from the internal result register, bout from the final borrow, and zero = (result == 0). All three update on the edge entering DONE.
  - Next state is always IDLE.
- Output hold: diff, bout and zero hold their values until the next DONE or reset. They do not change during SHIFT; partial results are never visible.
- Latency: start accepted at edge 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1. Back in IDLE at cycle WIDTH+2, where a new start is accepted. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 or in DONE: ignored. No queueing, no effect on the current operation.
- a, b and bin may change freely after the accepting edge.
- Reset mid-operation: abort immediately. No done pulse is issued, and outputs clear to 0.
- Arithmetic is unsigned, modulo 2^WIDTH. The counter is clog2(WIDTH+1) bits wide and does not wrap during an operation.

Test Plan:
1. WIDTH=8, a=100, b=37, bin=0, start for 1 cycle -> busy high for 8 cycles; done in cycle 9 after the start edge; diff=63, bout=0, zero=0.
2. a=5, b=9, bin=0 -> diff=252, bout=1, zero=0.
3. a=0, b=0, bin=1 -> diff=255, bout=1, zero=0. Then a=42, b=42, bin=0 -> diff=0, bout=0, zero=1.
4. start pulsed again at cycles 3 and 9 of an operation (a=200, b=1) with different operands -> both ignored; exactly one done pulse; diff=199. A start in the following IDLE cycle is accepted.
5. rst asserted at SHIFT cycle 4 of a=77, b=3 -> next cycle busy=0, diff=0, bout=0, zero=0; no done pulse. A fresh start of 10-4 then gives diff=6.
6. Random sweep: 1000 operations with random a, b, bin, compared against a reference model a-b-bin mod 256 and borrow -> all match; done spacing >= 10 cycles.
